// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit.
// Holds the FSM state encoding and the ResultSrc code that marks a load.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_t;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Watchdog cycle counter for the LSU bus access.
// Ports: clk, rst (sync, high), clear, inc, limit -> expired (count==limit).
module lsu_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    assign expired = (cnt == limit);

    // Saturates at the limit so a stalled FSM never wraps back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: one word access per M-stage instruction over a
// valid/ready bus, load data to M/W, stall_m holds the pipe meanwhile.
// Ports: M bundle in (ALUResult_m, WriteData_m, MemWrite_m, ResultSrc_m),
// stall_m/rdata_m/misalign_m/bus_err_m out, mem_req_* / mem_rsp_* bus.
// Optional watchdog: define LSU_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module mem_stage_lsu #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ALUResult_m,
    input  logic [DATA_W-1:0] WriteData_m,
    input  logic              MemWrite_m,
    input  logic [1:0]        ResultSrc_m,
    output logic              stall_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic              misalign_m,
    output logic              bus_err_m,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    import lsu_pkg::*;

    lsu_state_t state;
    lsu_state_t state_nx;

    logic access;
    logic misaligned;
    logic timeout;
    logic busy;

    assign access     = MemWrite_m || (ResultSrc_m == RESULT_SRC_MEM);
    assign misaligned = (ALUResult_m[1:0] != 2'b00);
    assign busy       = (state == REQ) || (state == RESP);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 2);

    logic ctr_clear;

    assign ctr_clear = (state == IDLE) && access;

    lsu_timeout_ctr #(
        .W(CW)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (ctr_clear),
        .inc    (busy),
        .limit  (CW'(TIMEOUT_CYC)),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_m <= 1'b0;
        end else begin
            bus_err_m <= busy && timeout;
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = |32'(TIMEOUT_CYC);
    assign timeout        = 1'b0;
    assign bus_err_m      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall_m  = 1'b0;
        unique case (state)
            IDLE: begin
                stall_m = access;
                if (access) begin
                    state_nx = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                stall_m = 1'b1;
                if (timeout) begin
                    state_nx = DONE;
                end else if (mem_req_ready) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                stall_m = 1'b1;
                if (timeout || mem_rsp_valid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request fields are latched only when leaving IDLE, so they stay
    // stable through REQ regardless of what the M-stage inputs do.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            rdata_m       <= '0;
            misalign_m    <= 1'b0;
        end else begin
            misalign_m <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        misalign_m <= 1'b1;
                    end else if (access) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= MemWrite_m;
                        mem_req_addr  <= {ALUResult_m[ADDR_W-1:2], 2'b00};
                        mem_req_wdata <= WriteData_m;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        mem_req_valid <= 1'b0;
                        if (!mem_req_we) begin
                            rdata_m <= '0;
                        end
                    end else if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (timeout) begin
                        if (!mem_req_we) begin
                            rdata_m <= '0;
                        end
                    end else if (mem_rsp_valid && !mem_req_we) begin
                        rdata_m <= mem_rsp_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
